uart_rx_capture: RTL and testbench

Synthesizable 8N1 UART receiver with an output byte FIFO.
- Sits directly downstream of pulpino_top's uart_tx pin.
- Converts the serial console stream into bytes for an on-chip or FPGA-side consumer, such as a console bridge or an end-of-test string matcher.
- Replaces the behavioural uart_bus model wherever a synthesizable sink is needed.

---
 rtl/uart_rx_capture.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: synthesizable 8N1 UART receiver feeding a byte FIFO.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data
// bits and the stop bit, and drives parity_err_o.
module uart_rx_capture #(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned BAUD_RATE   = 781250,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  input  logic                        clear_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        overflow_o,
  output logic                        parity_err_o
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bidx, bidx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push, ferr_n, perr_n;

  logic sync1, rx_s, rx_prev;
  logic fall;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop, drop;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Receiver state register, bit timing and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bidx        <= bidx_n;
      shreg       <= shreg_n;
      frame_err_o <= ferr_n;
    end
  end

  // Next-state logic; the counter free-runs and each state resets it on its sample point.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bidx_n  = bidx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (fall && rx_en_i) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bidx == 3'd7) state_n = S_PARITY;
`else
          if (bidx == 3'd7) state_n = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          perr_n  = (^shreg) ^ rx_s;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity-mismatch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_o <= 1'b0;
    else        parity_err_o <= perr_n;
  end
`else
  assign parity_err_o = 1'b0;
`endif

  assign valid_o = (level_o != '0);
  assign full    = (level_o == LVL_FULL);
  assign do_pop  = valid_o & ready_i & ~clear_i;
  // A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
  assign do_push = push & ~clear_i & (~full | do_pop);
  assign drop    = push & ~clear_i & full & ~do_pop;
  assign data_o  = mem[rd_ptr];

  // FIFO pointers, occupancy and sticky overflow; clear beats any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level_o <= level_o + LVL_W'(1);
      else if (!do_push && do_pop) level_o <= level_o - LVL_W'(1);
      if (drop) overflow_o <= 1'b1;
    end
  end

  // FIFO storage; reset so data_o reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed self-checking bench for uart_rx_capture (DIV = 32, FIFO_DEPTH = 16).
module tb_uart_rx_capture;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned PUSH_CYC = 338;
`else
  localparam int unsigned PUSH_CYC = 306;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_en_i = 1'b1;
  logic       clear_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [4:0] level_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       parity_err_o;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int f0;

  uart_rx_capture #(
    .CLK_FREQ_HZ(25000000),
    .BAUD_RATE  (781250),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_en_i     (rx_en_i),
    .clear_i     (clear_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (parity_err_o === 1'b1) perr_cnt <= perr_cnt + 1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; stop_low > 0 holds the stop bit low for that many bit times.
  task automatic send_raw(input logic [7:0] b, input int unsigned stop_low);
    rx_i = 1'b0;
    tick(32);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(32);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = ^b;
    tick(32);
`endif
    if (stop_low != 0) begin
      rx_i = 1'b0;
      tick(32 * stop_low);
    end
    rx_i = 1'b1;
    tick(32);
  endtask

  task automatic pop1;
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_perr", 32'(parity_err_o), 32'd0);

    // Empty pop is ignored
    pop1();
    check("empty_pop_level", 32'(level_o), 32'd0);

    // Single byte with exact latency
    fork
      send_raw(8'h55, 0);
      begin
        tick(PUSH_CYC);
        check("lat_before", 32'(valid_o), 32'd0);
        tick(1);
        check("lat_valid", 32'(valid_o), 32'd1);
        check("lat_data", 32'(data_o), 32'h55);
        check("lat_level", 32'(level_o), 32'd1);
      end
    join
    pop1();
    check("pop_valid", 32'(valid_o), 32'd0);

    // Overflow: 20 bytes, consumer stalled
    for (int i = 0; i < 20; i++) send_raw(8'(i), 0);
    check("ovf_level", 32'(level_o), 32'd16);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_seq", 32'(data_o), 32'(i));
      pop1();
    end
    check("ovf_drained", 32'(valid_o), 32'd0);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("clr_ovf", 32'(overflow_o), 32'd0);
    check("clr_level", 32'(level_o), 32'd0);

    // Short low glitch: false start
    f0 = ferr_cnt;
    rx_i = 1'b0;
    tick(8);
    rx_i = 1'b1;
    tick(400);
    check("glitch_level", 32'(level_o), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Long break in the stop bit, then a clean frame
    f0 = ferr_cnt;
    send_raw(8'hA3, 3);
    check("brk_level", 32'(level_o), 32'd0);
    check("brk_ferr", 32'(ferr_cnt - f0), 32'd1);
    tick(32);
    send_raw(8'h7E, 0);
    check("post_brk_level", 32'(level_o), 32'd1);
    check("post_brk_data", 32'(data_o), 32'h7E);
    check("post_brk_ferr", 32'(ferr_cnt - f0), 32'd1);
    pop1();

    // Receive disabled: frame ignored
    rx_en_i = 1'b0;
    send_raw(8'h5A, 0);
    check("dis_level", 32'(level_o), 32'd0);
    rx_en_i = 1'b1;

    // Enable dropped mid-frame: frame still completes
    fork
      send_raw(8'h3C, 0);
      begin
        tick(100);
        rx_en_i = 1'b0;
      end
    join
    rx_en_i = 1'b1;
    check("midoff_level", 32'(level_o), 32'd1);
    check("midoff_data", 32'(data_o), 32'h3C);
    pop1();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) send_raw(8'(8'h80 + i), 0);
    check("full_level", 32'(level_o), 32'd16);
    fork
      send_raw(8'h90, 0);
      begin
        tick(PUSH_CYC);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("pp_level", 32'(level_o), 32'd16);
        check("pp_ovf", 32'(overflow_o), 32'd0);
        check("pp_head", 32'(data_o), 32'h81);
      end
    join
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("clr2_level", 32'(level_o), 32'd0);
    check("clr2_valid", 32'(valid_o), 32'd0);

    // Reset in the middle of bit 4 of 0xF0
    f0 = ferr_cnt;
    fork
      send_raw(8'hF0, 0);
      begin
        tick(32 * 5 + 16);
        rst_n = 1'b0;
        tick(2);
        check("midrst_level", 32'(level_o), 32'd0);
        rst_n = 1'b1;
      end
    join
    tick(32);
    check("midrst_after", 32'(level_o), 32'd0);
    send_raw(8'h31, 0);
    check("midrst_level2", 32'(level_o), 32'd1);
    check("midrst_data", 32'(data_o), 32'h31);
    check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("no_perr", 32'(perr_cnt), 32'd0);
    pop1();

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: pulse reported, byte still pushed
    rx_i = 1'b0;
    tick(32);
    for (int i = 0; i < 8; i++) begin
      rx_i = (i == 0 || i == 4 || i == 5) ? 1'b1 : 1'b0;
      tick(32);
    end
    rx_i = 1'b0;
    tick(32);
    rx_i = 1'b1;
    tick(32);
    check("par_perr", 32'(perr_cnt), 32'd1);
    check("par_level", 32'(level_o), 32'd1);
    check("par_data", 32'(data_o), 32'h31);
    pop1();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
